// File: rtl/sm_gpio_ctrl.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : sm_gpio_ctrl                                               |
// | Description : Memory-mapped GPIO controller for the schoolMIPS data bus. |
// |               Per-pin direction register, atomic set/clear writes to the |
// |               output register, two-flop input synchroniser and an        |
// |               optional rising-edge interrupt.                            |
// | Config      : SM_GPIO_IRQ_EN (normally from sm_config.vh)                |
// |               defined   -> IE/IFG registers, edge detector, GpioIrq      |
// |               undefined -> IE/IFG read 0, writes ignored, GpioIrq = 0    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//
// Parameters
//   WIDTH       number of GPIO pins, 1..32
//   BASE        match value for bAddr[15:5] (default window 0xBEA0-0xBEBF)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   bAddr       byte address, bits [15:2] decoded
//   bWe         write strobe
//   bWData      write data, bits [WIDTH-1:0] used
//   bRData      registered read data (zero when the window is not selected)
//   GpioInput   asynchronous pad inputs
//   GpioOutput  output data register
//   GpioOe      per-pin output enable (1 = drive)
//   GpioIrq     level interrupt request (OR of pending flags)
//
// Register map (offset bAddr[4:2])
//   0 OUT      RW
//   1 IN       RO   synchronised pins
//   2 DIR      RW   1 = output
//   3 IE       RW   rising-edge interrupt enable
//   4 IFG      R/W1C
//   5 OUT_SET  WO   OUT |= data, reads return OUT
//   6 OUT_CLR  WO   OUT &= ~data, reads return OUT
//   7 reserved      reads 0, writes ignored
//------------------------------------------------------------------------------

`default_nettype none

module sm_gpio_ctrl #(
  parameter int          WIDTH = 16,
  parameter logic [10:0] BASE  = 11'h5F5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      bAddr,
  input  logic             bWe,
  input  logic [31:0]      bWData,
  output logic [31:0]      bRData,
  input  logic [WIDTH-1:0] GpioInput,
  output logic [WIDTH-1:0] GpioOutput,
  output logic [WIDTH-1:0] GpioOe,
  output logic             GpioIrq
);

  // Register offsets within the 32-byte window
  localparam logic [2:0] C_OFF_OUT     = 3'd0;
  localparam logic [2:0] C_OFF_IN      = 3'd1;
  localparam logic [2:0] C_OFF_DIR     = 3'd2;
  localparam logic [2:0] C_OFF_IE      = 3'd3;
  localparam logic [2:0] C_OFF_IFG     = 3'd4;
  localparam logic [2:0] C_OFF_OUT_SET = 3'd5;
  localparam logic [2:0] C_OFF_OUT_CLR = 3'd6;

  //--------------------------------------------------------------------------
  // Address decode
  //--------------------------------------------------------------------------
  logic             w_active;
  logic [2:0]       w_off;
  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;

  assign w_active = (bAddr[15:5] == BASE);
  assign w_off    = bAddr[4:2];
  assign w_wr     = bWe & w_active;
  assign w_wdata  = bWData[WIDTH-1:0];

  // Address bits outside the decoded field and write-data bits above WIDTH
  // are intentionally ignored; fold them into one sink net.
  logic w_unused;
  assign w_unused = ^{bAddr[31:16], bAddr[1:0], bWData};

  //--------------------------------------------------------------------------
  // Output data and direction registers
  //--------------------------------------------------------------------------
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_dir <= '0;
    end else if (w_wr) begin
      case (w_off)
        C_OFF_OUT:     r_out <= w_wdata;
        C_OFF_OUT_SET: r_out <= r_out | w_wdata;
        C_OFF_OUT_CLR: r_out <= r_out & ~w_wdata;
        C_OFF_DIR:     r_dir <= w_wdata;
        default:       ;
      endcase
    end
  end

  assign GpioOutput = r_out;
  assign GpioOe     = r_dir;

  //--------------------------------------------------------------------------
  // Two-flop input synchroniser
  //--------------------------------------------------------------------------
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= GpioInput;
      r_sync2 <= r_sync1;
    end
  end

  //--------------------------------------------------------------------------
  // Rising-edge interrupt logic
  //--------------------------------------------------------------------------
  logic [WIDTH-1:0] w_ie;
  logic [WIDTH-1:0] w_ifg;

`ifdef SM_GPIO_IRQ_EN
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_ie;
  logic [WIDTH-1:0] r_ifg;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_clr;

  // prev tracks sync2 from reset onward; IE resets to 0, so no edge can be
  // latched before prev has settled to the real pin level.
  assign w_rise = r_sync2 & ~r_prev;
  assign w_clr  = (w_wr && (w_off == C_OFF_IFG)) ? w_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_ie   <= '0;
      r_ifg  <= '0;
    end else begin
      r_prev <= r_sync2;
      if (w_wr && (w_off == C_OFF_IE)) begin
        r_ie <= w_wdata;
      end
      // A new edge wins over a simultaneous write-1-to-clear of the same bit.
      // Clearing IE leaves already pending flags untouched.
      r_ifg <= (r_ifg & ~w_clr) | (w_rise & r_ie);
    end
  end

  assign w_ie    = r_ie;
  assign w_ifg   = r_ifg;
  // Pure OR of flops so the request line carries no decode glitches.
  assign GpioIrq = |r_ifg;
`else
  assign w_ie    = '0;
  assign w_ifg   = '0;
  assign GpioIrq = 1'b0;
`endif

  //--------------------------------------------------------------------------
  // Read path: registered, zero outside the window so it can be OR-muxed
  // with the other bus slaves. Old register contents are returned when a
  // read and a write hit the same register in one cycle.
  //--------------------------------------------------------------------------
  logic [31:0] w_rdata;
  logic [31:0] r_rdata;

  always_comb begin
    w_rdata = 32'h0;
    case (w_off)
      C_OFF_OUT,
      C_OFF_OUT_SET,
      C_OFF_OUT_CLR: w_rdata = 32'(r_out);
      C_OFF_IN:      w_rdata = 32'(r_sync2);
      C_OFF_DIR:     w_rdata = 32'(r_dir);
      C_OFF_IE:      w_rdata = 32'(w_ie);
      C_OFF_IFG:     w_rdata = 32'(w_ifg);
      default:       w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'h0;
    end else begin
      r_rdata <= w_active ? w_rdata : 32'h0;
    end
  end

  assign bRData = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_sm_gpio_ctrl.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tb_sm_gpio_ctrl                                            |
// | Description : Directed self-checking bench for sm_gpio_ctrl, WIDTH=8,    |
// |               BASE=11'h5F5. Interrupt expectations follow whether        |
// |               SM_GPIO_IRQ_EN is defined in this compilation.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------

`default_nettype none

module tb_sm_gpio_ctrl;

  localparam int WIDTH = 8;

`ifdef SM_GPIO_IRQ_EN
  localparam bit C_IRQ = 1'b1;
`else
  localparam bit C_IRQ = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [31:0]      bAddr;
  logic             bWe;
  logic [31:0]      bWData;
  logic [31:0]      bRData;
  logic [WIDTH-1:0] GpioInput;
  logic [WIDTH-1:0] GpioOutput;
  logic [WIDTH-1:0] GpioOe;
  logic             GpioIrq;

  int vectors;
  int miscompares;

  sm_gpio_ctrl #(
    .WIDTH (WIDTH),
    .BASE  (11'h5F5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bAddr      (bAddr),
    .bWe        (bWe),
    .bWData     (bWData),
    .bRData     (bRData),
    .GpioInput  (GpioInput),
    .GpioOutput (GpioOutput),
    .GpioOe     (GpioOe),
    .GpioIrq    (GpioIrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Single-cycle write; returns 1 ns after the capturing edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bAddr  = addr;
    bWData = data;
    bWe    = 1'b1;
    @(posedge clk);
    #1;
    bWe    = 1'b0;
    bAddr  = 32'h0;
    bWData = 32'h0;
  endtask

  // Single-cycle read; data is bRData 1 ns after the loading edge.
  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    bAddr = addr;
    bWe   = 1'b0;
    @(posedge clk);
    #1;
    data  = bRData;
    bAddr = 32'h0;
  endtask

  logic [31:0] rdat;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bAddr       = 32'h0;
    bWe         = 1'b0;
    bWData      = 32'h0;
    GpioInput   = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(GpioOutput), 32'h0);
    check("rst_rdata", bRData, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- reset asserted in the middle of a write ----
    wr(32'hBEA0, 32'h55);
    check("pre_out", 32'(GpioOutput), 32'h55);
    wr(32'hBEA8, 32'h0F);
    check("pre_oe", 32'(GpioOe), 32'h0F);
    @(negedge clk);
    bAddr  = 32'hBEA0;
    bWData = 32'hAA;
    bWe    = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(GpioOutput), 32'h0);
    @(posedge clk);
    #1;
    check("midwr_out", 32'(GpioOutput), 32'h0);
    check("midwr_oe", 32'(GpioOe), 32'h0);
    check("midwr_irq", 32'(GpioIrq), 32'h0);
    @(negedge clk);
    bWe   = 1'b0;
    bAddr = 32'h0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(32'hBEA0 + 32'(i * 4), rdat);
      check($sformatf("rst_rd_off%0d", i * 4), rdat, 32'h0);
    end

    // ---- OUT / OUT_SET / OUT_CLR ----
    wr(32'hBEA0, 32'hA5);
    check("out_wr", 32'(GpioOutput), 32'hA5);
    wr(32'hBEB4, 32'h0F);
    check("out_set", 32'(GpioOutput), 32'hAF);
    wr(32'hBEB8, 32'h81);
    check("out_clr", 32'(GpioOutput), 32'h2E);
    rd(32'hBEA0, rdat);
    check("rd_out", rdat, 32'h2E);
    rd(32'hBEB4, rdat);
    check("rd_outset", rdat, 32'h2E);
    rd(32'hBEBC, rdat);
    check("rd_reserved", rdat, 32'h0);
    wr(32'hBEA0, 32'h1FF);
    check("out_trunc", 32'(GpioOutput), 32'hFF);
    rd(32'hBEA0, rdat);
    check("rd_trunc", rdat, 32'h0000_00FF);

    // read and write of the same register in one cycle returns old value
    wr(32'hBEA0, 32'h12);
    check("rdw_old", bRData, 32'hFF);
    check("rdw_new", 32'(GpioOutput), 32'h12);

    // ---- DIR ----
    wr(32'hBEA8, 32'hF0);
    check("dir_oe", 32'(GpioOe), 32'hF0);
    rd(32'hBEA8, rdat);
    check("rd_dir", rdat, 32'hF0);

    // ---- input synchroniser latency: visible only after E2 ----
    @(negedge clk);
    bAddr     = 32'hBEA4;
    GpioInput = 8'h3C;
    @(posedge clk); #1;
    check("in_e0", bRData, 32'h0);
    @(posedge clk); #1;
    check("in_e1", bRData, 32'h0);
    @(posedge clk); #1;
    check("in_e2", bRData, 32'h3C);
    bAddr = 32'h0;

    // ---- interrupt enable and rising edge ----
    wr(32'hBEAC, 32'h01);
    rd(32'hBEAC, rdat);
    check("rd_ie", rdat, C_IRQ ? 32'h01 : 32'h0);
    @(negedge clk);
    GpioInput = 8'h3D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("irq_e1", 32'(GpioIrq), 32'h0);
    @(posedge clk); #1;
    check("irq_e2", 32'(GpioIrq), 32'(C_IRQ));
    rd(32'hBEB0, rdat);
    check("rd_ifg", rdat, C_IRQ ? 32'h01 : 32'h0);

    // falling pin leaves the flag pending
    @(negedge clk);
    GpioInput = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    check("irq_fall_hold", 32'(GpioIrq), 32'(C_IRQ));

    // new edge coincides with the clear write: set wins
    @(negedge clk);
    GpioInput = 8'h3D;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bAddr  = 32'hBEB0;
    bWData = 32'h01;
    bWe    = 1'b1;
    @(posedge clk); #1;
    bWe    = 1'b0;
    bAddr  = 32'h0;
    check("irq_setwins", 32'(GpioIrq), 32'(C_IRQ));
    rd(32'hBEB0, rdat);
    check("rd_ifg_setwins", rdat, C_IRQ ? 32'h01 : 32'h0);

    // plain clear
    wr(32'hBEB0, 32'h01);
    check("irq_cleared", 32'(GpioIrq), 32'h0);
    rd(32'hBEB0, rdat);
    check("rd_ifg_cleared", rdat, 32'h0);

    // pin1 rises with IE bit1 = 0: no flag
    @(negedge clk);
    GpioInput = 8'h3F;
    repeat (4) @(posedge clk);
    #1;
    check("irq_masked", 32'(GpioIrq), 32'h0);
    rd(32'hBEB0, rdat);
    check("rd_ifg_masked", rdat, 32'h0);

    // ---- access outside the window ----
    wr(32'hBEC0, 32'h55);
    check("oow_rdata", bRData, 32'h0);
    check("oow_out", 32'(GpioOutput), 32'h12);
    check("oow_oe", 32'(GpioOe), 32'hF0);
    rd(32'hBEA0, rdat);
    check("oow_rd_out", rdat, 32'h12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sm_gpio_ctrl.md
# sm_gpio_ctrl

Parametrised memory-mapped GPIO controller for the schoolMIPS data bus. It replaces the fixed-width output/input port with a per-pin direction register and atomic set/clear writes. Inputs pass through a two-flop synchroniser, and an optional rising-edge interrupt is provided. It sits on the data-memory bus beside RAM, and its `bRData` is OR-muxed into the read path.

## Interface
Parameters:
- `WIDTH`, 16: number of GPIO pins; legal range 1..32.
- `BASE`, 11'h5F5: match value for `bAddr[15:5]`. The default window is 0xBEA0–0xBEBF.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `bAddr` in 32: byte address; only bits [15:2] are decoded.
- `bWe` in 1: write strobe.
- `bWData` in 32: write data.
- `bRData` out 32: registered read data.
- `GpioInput` in WIDTH: asynchronous pad inputs.
- `GpioOutput` out WIDTH: output data register.
- `GpioOe` out WIDTH: output enable per pin; 1 = drive.
- `GpioIrq` out 1: level interrupt request.

## Operation
- Window select: `active = (bAddr[15:5] == BASE)`.
- Register select: offset `bAddr[4:2]`.
- Register map (offset, name, access):
  - 0x00 OUT, RW
  - 0x04 IN, RO: synchronised pins
  - 0x08 DIR, RW: 1 = output
  - 0x0C IE, RW: rising-edge interrupt enable
  - 0x10 IFG, read / write-1-to-clear
  - 0x14 OUT_SET, WO: OUT |= data; reads return OUT
  - 0x18 OUT_CLR, WO: OUT &= ~data; reads return OUT
  - 0x1C reserved: reads 0, writes ignored
- Writes occur when `bWe & active`. Only `bWData[WIDTH-1:0]` is used. Bits WIDTH..31 of every register read as 0.
- `GpioOutput` = OUT. `GpioOe` = DIR. Both are driven directly from flops.
- Input path: `GpioInput` -> sync1 -> sync2 -> prev.
  - IN reads sync2.
  - Rising edge per bit: `rise = sync2 & ~prev`.
- IFG update per bit: `IFG <= (IFG & ~clr) | (rise & IE)`, where `clr` = the write data on an IFG write. When set and clear coincide, set wins.
- Clearing IE does not clear pending IFG bits.
- `GpioIrq = |IFG`: an OR of flops, with no other logic.
- There is no spurious edge after reset. IE resets to 0, so prev has settled before software can enable any edge.

## Timing
- Reset values: OUT, DIR, IE, IFG, sync1, sync2, prev and `bRData` are all 0. `GpioOutput`=0, `GpioOe`=0, `GpioIrq`=0.
- Reset is asynchronous on assertion and synchronous on release through the normal flops. Asserting reset mid-transfer aborts that transfer; no partial write is retained.
- Read latency is 1 cycle. `bRData` is loaded at every `clk` edge:
  - With the addressed register value when `active`.
  - With 0 when not `active`.
  - A read and a write to the same register in the same cycle return the old value.
- Write latency: a register and its outputs update at the edge where `bWe` is sampled high.
- Pin to IN: a pin stable before edge E0 is visible in sync2 after E1 and in `bRData` after E2 (read issued at E2).
- Pin to interrupt: with IE set, a rising pin stable before E0 sets IFG and `GpioIrq` after E2.
- An IFG clear write at edge Ec drops `GpioIrq` after Ec, unless a new edge on the same bit coincides.

## Configuration
- Macro `SM_GPIO_IRQ_EN`, from `sm_config.vh`.
- Defined: IE, IFG, prev and the edge logic are present, as described above.
- Undefined:
  - IE and IFG read as 0 and writes to them are ignored.
  - prev and the edge logic are not instantiated.
  - `GpioIrq` is tied to 0.
  - The synchroniser and all other registers are unchanged.

## Test plan
Bench setup: WIDTH=8, BASE=11'h5F5, macro defined.
- Reset: assert `rst_n`=0 mid-write to OUT -> `GpioOutput`=0x00, `GpioOe`=0x00, `GpioIrq`=0; after release, reads of every offset return 0.
- Write 0xA5 to 0xBEA0, then 0x0F to 0xBEB4, then 0x81 to 0xBEB8 -> OUT values after each write: 0xA5, then 0xAF, then 0x2E; a read of 0xBEA0 returns 0x2E one cycle later; a write of 0x1FF stores 0xFF.
- Write DIR=0xF0 -> `GpioOe`=0xF0; drive `GpioInput`=0x3C -> read of 0xBEA4 returns 0x3C no earlier than 3 edges after the pin change.
- Write IE=0x01; pulse pin0 0→1 -> IFG=0x01 and `GpioIrq`=1 two edges after sync; writing 0x01 to 0xBEB0 clears it.
- Pin0 rises in the same cycle as the IFG clear write -> IFG stays 0x01 and `GpioIrq` stays 1; pin1 rises with IE bit1=0 -> IFG bit1 stays 0.
- Access to 0xBEC0 (outside window) with `bWe`=1 -> no register changes and `bRData`=0; rebuild without the macro -> IE/IFG read 0 and `GpioIrq`=0 under edge stimulus.
